// File: rtl/arbitro_somador.sv
// Round-robin arbiter that shares one adder/subtractor between two requesters.
// Each requester runs a 4-phase req/done handshake; operands are latched at the grant edge.

module somador #(
  parameter int BITS = 63
) (
  input  logic          op_i,
  input  logic [BITS:0] a_i,
  input  logic [BITS:0] b_i,
  output logic [BITS:0] s_o,
  output logic          v_o
);
  logic [BITS:0] b_eff;

  // Subtraction is a + ~b + 1, so overflow reduces to the add rule applied to b_eff.
  assign b_eff = op_i ? b_i : ~b_i;
  assign s_o   = a_i + b_eff + {{BITS{1'b0}}, ~op_i};
  assign v_o   = (a_i[BITS] == b_eff[BITS]) && (s_o[BITS] != a_i[BITS]);
endmodule

module arbitro_somador #(
  parameter int BITS = 63
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [BITS:0] a0,
  input  logic [BITS:0] b0,
  input  logic [BITS:0] a1,
  input  logic [BITS:0] b1,
  output logic          done0,
  output logic          done1,
  output logic [BITS:0] result,
  output logic          v,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic          op_q, op_d;
  logic [BITS:0] a_q, a_d;
  logic [BITS:0] b_q, b_d;
  logic [BITS:0] result_q, result_d;
  logic          v_q, v_d;

  logic          win;
  logic          req_gnt;
  logic [BITS:0] sum_w;
  logic          ov_w;

  somador #(.BITS(BITS)) u_somador (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .s_o  (sum_w),
    .v_o  (ov_w)
  );

  // Requester 1 wins when alone, or when both ask and the pointer favours it.
  assign win     = req1 & (~req0 | ptr_q);
  assign req_gnt = gnt_q ? req1 : req0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    v_d      = v_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win;
          ptr_d   = ~win;
          op_d    = win ? op1 : op0;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = sum_w;
        v_d      = ov_w;
        state_d  = DONE;
      end
      DONE: begin
        if (!req_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done0  = (state_q == DONE) & ~gnt_q;
  assign done1  = (state_q == DONE) & gnt_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign v      = v_q;
endmodule

// File: tb/tb_arbitro_somador.sv
// Directed bench for arbitro_somador at BITS = 7: vector table plus handshake,
// round-robin, hold, early-drop and mid-operation reset sequences.

module tb_arbitro_somador;
  logic       clock, reset;
  logic       req0, req1, op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       done0, done1, v, busy;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sel;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  arbitro_somador #(.BITS(7)) dut (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .op0    (op0),
    .op1    (op1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .v      (v),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for a done pulse; returns the requester index, or -1 on timeout.
  task automatic wait_done(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done0 | done1) begin
        who = done1 ? 1 : 0;
        chk("both_done", {7'b0, done0 & done1}, 8'h00);
        break;
      end
    end
    if (who < 0) chk("done_timeout", 8'h00, 8'h01);
  endtask

  task automatic do_op(input logic sel, input logic op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res, input logic ov);
    @(negedge clock);
    if (sel) begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    else     begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
    @(posedge clock); #1;
    chk("exec_busy", {7'b0, busy}, 8'h01);
    chk("exec_done", {6'b0, done1, done0}, 8'h00);
    @(posedge clock); #1;
    chk("done_sel", {6'b0, done1, done0}, sel ? 8'h02 : 8'h01);
    chk("result", result, res);
    chk("v", {7'b0, v}, {7'b0, ov});
    chk("done_busy", {7'b0, busy}, 8'h01);
    @(negedge clock);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;
    chk("idle_busy", {7'b0, busy}, 8'h00);
    chk("idle_done", {6'b0, done1, done0}, 8'h00);
  endtask

  int who;
  int exp_who[4];
  logic [7:0] exp_res[4];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'd100, 8'd50,  8'h96, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h80,  8'h01,  8'h7F, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 8'd5,   8'd3,   8'h02, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'd50,  8'd100, 8'hCE, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'hFF,  8'h01,  8'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00,  8'h80,  8'h80, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'h80,  8'hFF,  8'h7F, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'h7F,  8'h7F,  8'hFE, 1'b1};
    exp_who = '{0, 1, 0, 1};
    exp_res = '{8'h02, 8'h05, 8'h02, 8'h05};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", result, 8'h00);
    chk("rst_v", {7'b0, v}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_done", {6'b0, done1, done0}, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Both requesters together; each re-raises once so the pointer decides.
    op0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
    op1 = 1'b0; a1 = 8'd9; b1 = 8'd4;
    req0 = 1'b1; req1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_done(who);
      chk("rr_order", who[7:0], exp_who[g][7:0]);
      chk("rr_result", result, exp_res[g]);
      @(negedge clock);
      if (who == 1) req1 = 1'b0; else req0 = 1'b0;
      @(posedge clock); #1;
      chk("rr_idle", {7'b0, busy}, 8'h00);
      @(negedge clock);
      if (g < 2) begin
        if (who == 1) req1 = 1'b1; else req0 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ov);

    // Hold req0 in DONE while req1 waits.
    @(negedge clock);
    op0 = 1'b1; a0 = 8'd10; b0 = 8'd20; req0 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("hold_first", {6'b0, done1, done0}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("hold_done0", {6'b0, done1, done0}, 8'h01);
      chk("hold_result", result, 8'd30);
      if (i == 2) begin op1 = 1'b0; a1 = 8'd7; b1 = 8'd2; req1 = 1'b1; end
    end
    @(negedge clock);
    req0 = 1'b0;
    @(posedge clock); #1;
    chk("drop_idle", {7'b0, busy}, 8'h00);
    chk("drop_done", {6'b0, done1, done0}, 8'h00);
    @(posedge clock); #1;
    chk("pend_grant", {7'b0, busy}, 8'h01);
    chk("pend_result_stable", result, 8'd30);
    @(posedge clock); #1;
    chk("pend_done1", {6'b0, done1, done0}, 8'h02);
    chk("pend_result", result, 8'd5);
    @(negedge clock);
    req1 = 1'b0;
    @(posedge clock);

    // Early drop with operands changed after the grant.
    @(negedge clock);
    op0 = 1'b1; a0 = 8'd3; b0 = 8'd4; req0 = 1'b1;
    @(posedge clock); #1;
    chk("early_busy", {7'b0, busy}, 8'h01);
    @(negedge clock);
    req0 = 1'b0; op0 = 1'b0; a0 = 8'd100; b0 = 8'd100;
    @(posedge clock); #1;
    chk("early_done", {6'b0, done1, done0}, 8'h01);
    chk("early_result", result, 8'd7);
    chk("early_v", {7'b0, v}, 8'h00);
    @(posedge clock); #1;
    chk("early_pulse", {6'b0, done1, done0}, 8'h00);
    chk("early_idle", {7'b0, busy}, 8'h00);

    // Reset in EXEC: v is 1 beforehand and the pointer favours requester 1.
    do_op(1'b0, 1'b1, 8'h7F, 8'h01, 8'h80, 1'b1);
    @(negedge clock);
    op0 = 1'b1; a0 = 8'd5; b0 = 8'd5; req0 = 1'b1;
    @(posedge clock); #1;
    chk("pre_rst_busy", {7'b0, busy}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_result", result, 8'h00);
    chk("mid_rst_v", {7'b0, v}, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    chk("mid_rst_done", {6'b0, done1, done0}, 8'h00);
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("post_rst_quiet", {5'b0, busy, done1, done0}, 8'h00);
    end
    @(negedge clock);
    op0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
    op1 = 1'b0; a1 = 8'd9; b1 = 8'd4;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(who);
    chk("ptr_reset_who", who[7:0], 8'h00);
    chk("ptr_reset_res", result, 8'h02);
    @(negedge clock);
    req0 = 1'b0;
    wait_done(who);
    chk("ptr_next_who", who[7:0], 8'h01);
    chk("ptr_next_res", result, 8'h05);
    @(negedge clock);
    req1 = 1'b0;
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
